score_display_ctrl: RTL and testbench

SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

---
 rtl/score_display_ctrl_pkg.sv | 21 ++
 rtl/score_display_ctrl_bin2dec_iter.sv | 34 +++
 rtl/score_display_ctrl.sv | 142 ++++++++++++++
 tb/tb_score_display_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/score_display_ctrl_pkg.sv
// Shared display codes, FSM state types and score saturation helper
// for the score display controller.
package score_display_ctrl_pkg;

  localparam logic [3:0] C_BLANK = 4'd10;
  localparam logic [3:0] C_DASH  = 4'd11;
  localparam logic [3:0] C_P     = 4'd12;
  localparam logic [3:0] C_R     = 4'd13;
  localparam logic [3:0] C_E     = 4'd14;
  localparam logic [3:0] C_F     = 4'd15;

  localparam logic [6:0] SCORE_MAX = 7'd99;

  typedef enum logic [1:0] {D_IDLE, D_PLAY, D_PAUSE, D_OVER} disp_state_t;
  typedef enum logic {CV_IDLE, CV_BUSY} cv_state_t;

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > SCORE_MAX) ? SCORE_MAX : v;
  endfunction

endpackage

// File: rtl/score_display_ctrl_bin2dec_iter.sv
// One side of the score converter: loads a saturated score, then
// subtracts 10 per step until the remainder is a single digit.
module bin2dec_iter
  import score_display_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       step,
  input  logic [6:0] value,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done
);

  logic [6:0] rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem  <= '0;
      tens <= '0;
    end else if (load) begin
      rem  <= sat99(value);
      tens <= '0;
    end else if (step && !done) begin
      rem  <= rem - 7'd10;
      tens <= tens + 4'd1;
    end
  end

  assign done = (rem < 7'd10);
  assign ones = rem[3:0];

endmodule

// File: rtl/score_display_ctrl.sv
// Scoreboard display controller: iterative binary-to-decimal score conversion
// plus a game-state display FSM with blinking. Define SCORE_LZB_EN to blank zero tens digits.
module score_display_ctrl
  import score_display_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       game_over,
  input  logic [6:0] score_l,
  input  logic [6:0] score_r,
  input  logic       score_valid,
  output logic       score_ready,
  output logic [3:0] digit5,
  output logic [3:0] digit4,
  output logic [3:0] digit3,
  output logic [3:0] digit2,
  output logic [3:0] digit1,
  output logic [3:0] digit0
);

  localparam int unsigned CW = $clog2(BLINK_DIV);

  cv_state_t   cv_state;
  disp_state_t d_state, d_next;

  logic          accept, busy, clear_digits;
  logic [3:0]    cv_tens_l, cv_ones_l, cv_tens_r, cv_ones_r;
  logic          done_l, done_r;
  logic [3:0]    lt, lo, rt, ro;
  logic [3:0]    lt_show, rt_show;
  logic [CW-1:0] blink_cnt;
  logic          blink_on;
  logic          l_gt, r_gt, blank_l, blank_r;
  logic [23:0]   disp_next;

  assign score_ready  = (cv_state == CV_IDLE);
  assign accept       = score_valid && score_ready;
  assign busy         = (cv_state == CV_BUSY);
  assign clear_digits = (d_state == D_IDLE) && start;

  bin2dec_iter u_conv_l (
    .clk(clk), .reset(reset), .load(accept), .step(busy), .value(score_l),
    .tens(cv_tens_l), .ones(cv_ones_l), .done(done_l)
  );

  bin2dec_iter u_conv_r (
    .clk(clk), .reset(reset), .load(accept), .step(busy), .value(score_r),
    .tens(cv_tens_r), .ones(cv_ones_r), .done(done_r)
  );

  // Committed digits live with the converter; a same-cycle commit beats the clear on game start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cv_state <= CV_IDLE;
      lt <= '0;
      lo <= '0;
      rt <= '0;
      ro <= '0;
    end else begin
      case (cv_state)
        CV_IDLE: if (score_valid) cv_state <= CV_BUSY;
        CV_BUSY: if (done_l && done_r) cv_state <= CV_IDLE;
        default: cv_state <= CV_IDLE;
      endcase
      if (busy && done_l && done_r) begin
        lt <= cv_tens_l;
        lo <= cv_ones_l;
        rt <= cv_tens_r;
        ro <= cv_ones_r;
      end else if (clear_digits) begin
        lt <= '0;
        lo <= '0;
        rt <= '0;
        ro <= '0;
      end
    end
  end

  always_comb begin
    d_next = d_state;
    case (d_state)
      D_IDLE:  if (start) d_next = D_PLAY;
      D_PLAY:  if (game_over) d_next = D_OVER;
               else if (pause) d_next = D_PAUSE;
      D_PAUSE: if (game_over) d_next = D_OVER;
               else if (pause) d_next = D_PLAY;
      D_OVER:  if (start) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

`ifdef SCORE_LZB_EN
  assign lt_show = (lt == 4'd0) ? C_BLANK : lt;
  assign rt_show = (rt == 4'd0) ? C_BLANK : rt;
`else
  assign lt_show = lt;
  assign rt_show = rt;
`endif

  assign l_gt    = {lt, lo} > {rt, ro};
  assign r_gt    = {rt, ro} > {lt, lo};
  assign blank_l = !blink_on && !r_gt;
  assign blank_r = !blink_on && !l_gt;

  always_comb begin
    disp_next = {C_P, C_R, C_E, C_BLANK, C_BLANK, C_BLANK};
    case (d_state)
      D_PLAY:  disp_next = {lt_show, lo, C_DASH, C_DASH, rt_show, ro};
      D_PAUSE: disp_next = {lt_show, lo, (blink_on ? C_P : C_BLANK), C_BLANK, rt_show, ro};
      D_OVER:  disp_next = {(blank_l ? {C_BLANK, C_BLANK} : {lt_show, lo}), C_F, C_F,
                            (blank_r ? {C_BLANK, C_BLANK} : {rt_show, ro})};
      default: disp_next = {C_P, C_R, C_E, C_BLANK, C_BLANK, C_BLANK};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_state   <= D_IDLE;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
      {digit5, digit4, digit3, digit2, digit1, digit0} <=
        {C_P, C_R, C_E, C_BLANK, C_BLANK, C_BLANK};
    end else begin
      d_state <= d_next;
      if (d_next != d_state) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
      {digit5, digit4, digit3, digit2, digit1, digit0} <= disp_next;
    end
  end

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl with a short blink period.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, pause = 1'b0, game_over = 1'b0;
  logic [6:0] score_l = '0, score_r = '0;
  logic       score_valid = 1'b0;
  logic       score_ready;
  logic [3:0] digit5, digit4, digit3, digit2, digit1, digit0;
  logic [23:0] digs;

  int checks = 0;
  int errors = 0;

`ifdef SCORE_LZB_EN
  localparam logic [3:0] TZ = 4'd10;
`else
  localparam logic [3:0] TZ = 4'd0;
`endif
  localparam logic [23:0] IDLE_PAT = 24'hCDEAAA;

  assign digs = {digit5, digit4, digit3, digit2, digit1, digit0};

  score_display_ctrl #(.BLINK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .game_over(game_over),
    .score_l(score_l), .score_r(score_r), .score_valid(score_valid),
    .score_ready(score_ready),
    .digit5(digit5), .digit4(digit4), .digit3(digit3),
    .digit2(digit2), .digit1(digit1), .digit0(digit0)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (digs !== IDLE_PAT) begin
      errors++;
      $display("FAIL reset_digits: got %h expected %h", digs, IDLE_PAT);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (digs !== IDLE_PAT || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got %h ready %b expected %h ready 1", digs, score_ready, IDLE_PAT);
    end
  endtask

  task automatic test_convert();
    logic [23:0] exp;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    exp = {TZ, 4'd0, 4'd11, 4'd11, TZ, 4'd0};
    checks++;
    if (digs !== exp) begin
      errors++;
      $display("FAIL play_zero: got %h expected %h", digs, exp);
    end
    score_l = 7'd37; score_r = 7'd5; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (score_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready_%0d: got %b expected 0", k, score_ready);
      end
      tick();
    end
    checks++;
    if (score_ready !== 1'b1 || digs !== exp) begin
      errors++;
      $display("FAIL commit_edge: got ready %b digits %h expected ready 1 digits %h", score_ready, digs, exp);
    end
    tick();
    exp = {4'd3, 4'd7, 4'd11, 4'd11, TZ, 4'd5};
    checks++;
    if (digs !== exp) begin
      errors++;
      $display("FAIL conv_37_5: got %h expected %h", digs, exp);
    end
  endtask

  task automatic test_saturate();
    logic [23:0] exp;
    score_l = 7'd120; score_r = 7'd42; score_valid = 1'b1;
    tick();
    score_l = 7'd1; score_r = 7'd1;
    tick(); tick();
    score_valid = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    exp = {4'd9, 4'd9, 4'd11, 4'd11, 4'd4, 4'd2};
    checks++;
    if (digs !== exp || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL saturate_ignore: got %h ready %b expected %h ready 1", digs, score_ready, exp);
    end
  endtask

  task automatic test_pause();
    logic [23:0] exp;
    pause = 1'b1; tick(); pause = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = ((k >= 5 && k <= 8) ? {4'd9, 4'd9, 4'd10, 4'd10, 4'd4, 4'd2}
                                : {4'd9, 4'd9, 4'd12, 4'd10, 4'd4, 4'd2});
      checks++;
      if (digs !== exp) begin
        errors++;
        $display("FAIL pause_blink_%0d: got %h expected %h", k, digs, exp);
      end
    end
    pause = 1'b1; tick(); pause = 1'b0;
    exp = {4'd9, 4'd9, 4'd11, 4'd11, 4'd4, 4'd2};
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (digs !== exp) begin
        errors++;
        $display("FAIL resume_%0d: got %h expected %h", k, digs, exp);
      end
    end
  endtask

  task automatic test_game_over();
    logic [23:0] exp;
    score_l = 7'd11; score_r = 7'd7; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    exp = {4'd1, 4'd1, 4'd11, 4'd11, TZ, 4'd7};
    checks++;
    if (digs !== exp) begin
      errors++;
      $display("FAIL conv_11_7: got %h expected %h", digs, exp);
    end
    game_over = 1'b1; pause = 1'b1; tick(); game_over = 1'b0; pause = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = ((k >= 5 && k <= 8) ? {4'd10, 4'd10, 4'd15, 4'd15, TZ, 4'd7}
                                : {4'd1, 4'd1, 4'd15, 4'd15, TZ, 4'd7});
      checks++;
      if (digs !== exp) begin
        errors++;
        $display("FAIL over_blink_%0d: got %h expected %h", k, digs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    logic [23:0] exp;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (digs !== IDLE_PAT) begin
      errors++;
      $display("FAIL over_to_idle: got %h expected %h", digs, IDLE_PAT);
    end
    start = 1'b1; tick(); start = 1'b0;
    score_l = 7'd99; score_r = 7'd88; score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (digs !== IDLE_PAT || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %h ready %b expected %h ready 1", digs, score_ready, IDLE_PAT);
    end
    tick();
    reset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 14; k++) tick();
    exp = {TZ, 4'd0, 4'd11, 4'd11, TZ, 4'd0};
    checks++;
    if (digs !== exp || score_ready !== 1'b1) begin
      errors++;
      $display("FAIL no_stale_commit: got %h ready %b expected %h ready 1", digs, score_ready, exp);
    end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturate();
    test_pause();
    test_game_over();
    test_reset_mid_conversion();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
